// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet pool: default geometry, direction
// encoding and the free-slot priority picker.
package bullet_pkg;

  localparam int unsigned X_W_DEF   = 11;
  localparam int unsigned Y_W_DEF   = 10;
  localparam int unsigned MAX_X_DEF = 1279;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // Lowest set bit of a mask (up to 16 slots) as index plus a found flag.
  function automatic pick_t lowest_set(input logic [15:0] mask);
    pick_t r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (mask[i] && !r.found) begin
        r.found = 1'b1;
        r.idx   = i[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One projectile slot: holds position, direction and alive flag, moves on
// each frame tick and retires itself when it would leave the screen.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int unsigned X_W    = X_W_DEF,
  parameter int unsigned Y_W    = Y_W_DEF,
  parameter int unsigned MAX_X  = MAX_X_DEF,
  parameter int unsigned STEP_X = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           load,
  input  logic           kill,
  input  logic [X_W-1:0] spawn_x,
  input  logic [Y_W-1:0] spawn_y,
  input  logic           spawn_dir,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           alive,
  output logic           dir
);

  localparam logic [X_W:0] STEP_W = (X_W+1)'(STEP_X);
  localparam logic [X_W:0] MAX_W  = (X_W+1)'(MAX_X);

  dir_t         dir_q;
  logic [X_W:0] x_fwd;
  logic         off_right;
  logic         off_left;

  // Candidate moves, one bit wider than x so the right edge cannot wrap.
  always_comb begin
    x_fwd     = {1'b0, x} + STEP_W;
    off_right = (x_fwd > MAX_W);
    off_left  = ({1'b0, x} < STEP_W);
  end

  assign dir = dir_q;

  // Kill has priority over everything; otherwise spawn-load or move on tick.
  // Load only ever targets a dead slot, so it never collides with a live kill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      alive <= 1'b0;
      dir_q <= DIR_LEFT;
    end else if (kill && alive) begin
      alive <= 1'b0;
    end else if (tick) begin
      if (load) begin
        x     <= spawn_x;
        y     <= spawn_y;
        dir_q <= dir_t'(spawn_dir);
        alive <= 1'b1;
      end else if (alive) begin
        if (dir_q == DIR_RIGHT) begin
          if (off_right) alive <= 1'b0;
          else           x     <= x_fwd[X_W-1:0];
        end else begin
          if (off_left)  alive <= 1'b0;
          else           x     <= x - STEP_W[X_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// Pool of N_BULLETS projectile slots fed from one spawn source (the player).
// Holds the spawn cooldown, lowest-free-slot arbitration, spawn_ok pulse and
// the packing of per-slot state onto flat output buses.
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int unsigned N_BULLETS = 4,
  parameter int unsigned X_W       = X_W_DEF,
  parameter int unsigned Y_W       = Y_W_DEF,
  parameter int unsigned MAX_X     = MAX_X_DEF,
  parameter int unsigned STEP_X    = 8,
  parameter int unsigned COOLDOWN  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     attack,
  input  logic                     defend,
  input  logic                     face,
  input  logic [X_W-1:0]           xPlayer,
  input  logic [Y_W-1:0]           yPlayer,
  input  logic [N_BULLETS-1:0]     kill,
  output logic [N_BULLETS*X_W-1:0] x,
  output logic [N_BULLETS*Y_W-1:0] y,
  output logic [N_BULLETS-1:0]     alive,
  output logic [N_BULLETS-1:0]     dir,
  output logic                     spawn_ok,
  output logic                     full
);

  localparam int unsigned CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [CW-1:0]        cool;
  logic [15:0]          free16;
  pick_t                pick;
  logic                 spawn_go;
  logic [N_BULLETS-1:0] load;

  // Free mask is taken from alive before this tick's retirements, so a slot
  // that retires on a tick only becomes reusable on the following tick.
  always_comb begin
    free16                = '0;
    free16[N_BULLETS-1:0] = ~alive;
    pick                  = lowest_set(free16);
    spawn_go              = tick && attack && !defend && (cool == '0) && pick.found;
  end

  // Cooldown counts down on ticks and reloads on every successful spawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cool     <= '0;
      spawn_ok <= 1'b0;
    end else begin
      spawn_ok <= spawn_go;
      if (tick) begin
        if (spawn_go)          cool <= CW'(COOLDOWN);
        else if (cool != '0)   cool <= cool - CW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < N_BULLETS; gi++) begin : g_slot
    assign load[gi] = spawn_go && (pick.idx == 4'(gi));

    bullet_slot #(
      .X_W    (X_W),
      .Y_W    (Y_W),
      .MAX_X  (MAX_X),
      .STEP_X (STEP_X)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .load      (load[gi]),
      .kill      (kill[gi]),
      .spawn_x   (xPlayer),
      .spawn_y   (yPlayer),
      .spawn_dir (face),
      .x         (x[gi*X_W +: X_W]),
      .y         (y[gi*Y_W +: Y_W]),
      .alive     (alive[gi]),
      .dir       (dir[gi])
    );
  end

  assign full = &alive;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: expectations are queued as stimulus is
// driven and checked against the outputs after the following clock edge.
module tb_bullet_pool;

  localparam int unsigned N   = 4;
  localparam int unsigned XW  = 11;
  localparam int unsigned YW  = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            tick;
  logic            attack;
  logic            defend;
  logic            face;
  logic [XW-1:0]   xPlayer;
  logic [YW-1:0]   yPlayer;
  logic [N-1:0]    kill;
  logic [N*XW-1:0] x;
  logic [N*YW-1:0] y;
  logic [N-1:0]    alive;
  logic [N-1:0]    dir;
  logic            spawn_ok;
  logic            full;

  bullet_pool #(
    .N_BULLETS (N),
    .X_W       (XW),
    .Y_W       (YW),
    .MAX_X     (1279),
    .STEP_X    (8),
    .COOLDOWN  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .attack   (attack),
    .defend   (defend),
    .face     (face),
    .xPlayer  (xPlayer),
    .yPlayer  (yPlayer),
    .kill     (kill),
    .x        (x),
    .y        (y),
    .alive    (alive),
    .dir      (dir),
    .spawn_ok (spawn_ok),
    .full     (full)
  );

  always #5 clk = ~clk;

  typedef enum int { K_X, K_Y, K_ALIVE, K_DIR, K_SPAWN, K_FULL } kind_t;

  typedef struct {
    string       tag;
    kind_t       kind;
    int          slot;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic expect_val(input string tag, input kind_t kind, input int slot,
                            input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.slot = slot;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input kind_t kind, input int slot);
    logic [31:0] r;
    r = '0;
    case (kind)
      K_X:     r = 32'(x[slot*XW +: XW]);
      K_Y:     r = 32'(y[slot*YW +: YW]);
      K_ALIVE: r = 32'(alive);
      K_DIR:   r = 32'(dir[slot]);
      K_SPAWN: r = 32'(spawn_ok);
      K_FULL:  r = 32'(full);
      default: r = '1;
    endcase
    return r;
  endfunction

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind, e.slot);
      n_assert++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    tick    = 1'b0;
    attack  = 1'b0;
    defend  = 1'b0;
    face    = 1'b0;
    kill    = '0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    xPlayer = '0;
    yPlayer = '0;
    do_reset();

    // Reset state
    expect_val("rst_alive", K_ALIVE, 0, 0);
    expect_val("rst_x0",    K_X,     0, 0);
    expect_val("rst_y3",    K_Y,     3, 0);
    expect_val("rst_spawn", K_SPAWN, 0, 0);
    expect_val("rst_full",  K_FULL,  0, 0);
    check_all();

    // 1: auto-fire every 5 ticks into slots 0..3, then pool full
    attack = 1'b1; face = 1'b1; xPlayer = 100; yPlayer = 50; tick = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      n = (k / 5 + 1 > 4) ? 4 : k / 5 + 1;
      expect_val($sformatf("t1_spawn_k%0d", k), K_SPAWN, 0, ((k % 5 == 0) && k <= 15) ? 1 : 0);
      expect_val($sformatf("t1_full_k%0d", k),  K_FULL,  0, (k >= 15) ? 1 : 0);
      expect_val($sformatf("t1_alive_k%0d", k), K_ALIVE, 0, (1 << n) - 1);
      expect_val($sformatf("t1_x0_k%0d", k),    K_X,     0, 100 + 8 * k);
      if ((k % 5 == 0) && k <= 15)
        expect_val($sformatf("t1_xnew_k%0d", k), K_X, k / 5, 100);
      cyc();
    end

    // 2: leftward bullet retires at the left edge, x holds
    do_reset();
    face = 1'b0; xPlayer = 20; yPlayer = 77; attack = 1'b1; tick = 1'b1;
    expect_val("t2_x_spawn", K_X, 0, 20);
    expect_val("t2_y",       K_Y, 0, 77);
    expect_val("t2_dir",     K_DIR, 0, 0);
    cyc();
    attack = 1'b0;
    expect_val("t2_x_12", K_X, 0, 12);
    cyc();
    expect_val("t2_x_4",     K_X,     0, 4);
    expect_val("t2_alive_4", K_ALIVE, 0, 1);
    cyc();
    expect_val("t2_retire_alive", K_ALIVE, 0, 0);
    expect_val("t2_retire_x",     K_X,     0, 4);
    cyc();

    // 3: rightward bullet retires past MAX_X, x holds
    do_reset();
    face = 1'b1; xPlayer = 1262; attack = 1'b1; tick = 1'b1;
    expect_val("t3_dir", K_DIR, 0, 1);
    cyc();
    attack = 1'b0;
    expect_val("t3_x_1270", K_X, 0, 1270);
    cyc();
    expect_val("t3_x_1278",     K_X,     0, 1278);
    expect_val("t3_alive_1278", K_ALIVE, 0, 1);
    cyc();
    expect_val("t3_retire_alive", K_ALIVE, 0, 0);
    expect_val("t3_retire_x",     K_X,     0, 1278);
    cyc();

    // 4: defend blocks spawning; release spawns on the next tick
    do_reset();
    face = 1'b1; xPlayer = 200; attack = 1'b1; defend = 1'b1; tick = 1'b1;
    for (int k = 0; k < 10; k++) begin
      expect_val($sformatf("t4_def_spawn_k%0d", k), K_SPAWN, 0, 0);
      expect_val($sformatf("t4_def_alive_k%0d", k), K_ALIVE, 0, 0);
      cyc();
    end
    defend = 1'b0;
    expect_val("t4_rel_spawn", K_SPAWN, 0, 1);
    expect_val("t4_rel_alive", K_ALIVE, 0, 1);
    expect_val("t4_rel_x",     K_X,     0, 200);
    cyc();

    // 5: kill slot 1 on a tick; next spawn reuses slot 1, not slot 3
    do_reset();
    face = 1'b1; xPlayer = 100; attack = 1'b1; tick = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      kill = (k == 11) ? 4'b0010 : 4'b0000;
      if (k > 10) xPlayer = 300;
      expect_val($sformatf("t5_spawn_k%0d", k), K_SPAWN, 0,
                 (k == 0 || k == 5 || k == 10 || k == 15) ? 1 : 0);
      if (k == 11) begin
        expect_val("t5_kill_alive", K_ALIVE, 0, 4'b0101);
        expect_val("t5_kill_x1",    K_X,     1, 140);
        expect_val("t5_kill_x0",    K_X,     0, 188);
        expect_val("t5_kill_x2",    K_X,     2, 108);
      end
      if (k == 15) begin
        expect_val("t5_reuse_alive", K_ALIVE, 0, 4'b0111);
        expect_val("t5_reuse_x1",    K_X,     1, 300);
      end
      cyc();
    end
    kill = '0;

    // 6: tick low freezes flight; async reset clears before the next edge
    tick = 1'b0; attack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_val($sformatf("t6_frz_x0_k%0d", k), K_X,     0, 220);
      expect_val($sformatf("t6_frz_x1_k%0d", k), K_X,     1, 300);
      expect_val($sformatf("t6_frz_x2_k%0d", k), K_X,     2, 140);
      expect_val($sformatf("t6_frz_al_k%0d", k), K_ALIVE, 0, 4'b0111);
      cyc();
    end
    rst_n = 1'b0;
    expect_val("t6_arst_alive", K_ALIVE, 0, 0);
    expect_val("t6_arst_x0",    K_X,     0, 0);
    expect_val("t6_arst_x1",    K_X,     1, 0);
    expect_val("t6_arst_y0",    K_Y,     0, 0);
    expect_val("t6_arst_spawn", K_SPAWN, 0, 0);
    #1;
    check_all();
    #2;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
